// File: rtl/cost_table_pkg.sv
// Shared definitions for the cost_table block.
// Holds the FSM state encoding, the default matrix geometry, and the
// saturation limit and helper used by the lookup counter.
package cost_table_pkg;

    localparam int          N_DEF       = 8;
    localparam int          COST_W_DEF  = 7;
    localparam logic [15:0] LOOKUPS_MAX = 16'hFFFF;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SERVE = 2'd2
    } state_t;

    // Increment that sticks at the maximum instead of wrapping.
    function automatic logic [15:0] sat_inc16(input logic [15:0] v);
        return (v == LOOKUPS_MAX) ? v : v + 16'd1;
    endfunction

endpackage

// File: rtl/cost_table_if.sv
// Bus interface of cost_table.
// master: drives Start, LdValid, LdData, W, J; observes LdReady, Cost,
//         Ready, LoadErr, Lookups.
// slave : the cost_table side (mirror of master).
interface cost_table_if
    import cost_table_pkg::*;
#(
    parameter int COST_W = COST_W_DEF
);
    logic              Start;
    logic              LdValid;
    logic [COST_W-1:0] LdData;
    logic              LdReady;
    logic [2:0]        W;
    logic [2:0]        J;
    logic [COST_W-1:0] Cost;
    logic              Ready;
    logic              LoadErr;
    logic [15:0]       Lookups;

    modport master (
        output Start, LdValid, LdData, W, J,
        input  LdReady, Cost, Ready, LoadErr, Lookups
    );

    modport slave (
        input  Start, LdValid, LdData, W, J,
        output LdReady, Cost, Ready, LoadErr, Lookups
    );
endinterface

// File: rtl/cost_table_mem.sv
// cost_mem: N*N x COST_W cost storage.
// Ports: CLK; we/waddr/wdata synchronous write port;
//        raddr/rdata combinational read port. Contents are never reset.
module cost_mem #(
    parameter int DEPTH  = 64,
    parameter int COST_W = 7,
    parameter int AW     = 6
) (
    input  logic              CLK,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [COST_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [COST_W-1:0] rdata
);
    logic [COST_W-1:0] mem_r [DEPTH];

    // Synchronous write port.
    always_ff @(posedge CLK) begin
        if (we) begin
            mem_r[waddr] <= wdata;
        end
    end

    assign rdata = mem_r[raddr];
endmodule

// File: rtl/cost_table.sv
// cost_table: loads an N x N cost matrix row-major and serves lookups.
// Ports: CLK (rising edge), RST (synchronous, active-low),
//        bus (cost_table_if.slave): Start/LdValid/LdData load handshake with
//        LdReady, W/J lookup indices, Cost/Ready results, LoadErr sticky
//        misuse flag, Lookups count of index changes while serving.
module cost_table
    import cost_table_pkg::*;
#(
    parameter int N      = N_DEF,
    parameter int COST_W = COST_W_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    cost_table_if.slave  bus
);
    localparam int            DEPTH = N * N;
    localparam int            AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW-1:0] LAST  = AW'(DEPTH - 1);

    state_t            state_r;
    state_t            state_nxt_s;
    logic [AW-1:0]     cnt_r;
    logic              accept_s;
    logic              last_s;
    logic [5:0]        wj_s;
    logic [5:0]        prev_wj_r;
    logic              in_range_s;
    logic [AW-1:0]     raddr_s;
    logic [COST_W-1:0] rdata_s;
    logic [15:0]       lookups_r;
    logic              load_err_r;

    assign last_s = (cnt_r == LAST);
    assign wj_s   = {bus.W, bus.J};

    // State register.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Next-state logic; Start always wins and (re)starts a load without
    // accepting the entry presented on that edge.
    always_comb begin
        state_nxt_s = state_r;
        accept_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (bus.Start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            LOAD: begin
                if (bus.Start) begin
                    state_nxt_s = LOAD;
                end else if (bus.LdValid) begin
                    accept_s = 1'b1;
                    if (last_s) begin
                        state_nxt_s = SERVE;
                    end else begin
                        state_nxt_s = LOAD;
                    end
                end else begin
                    state_nxt_s = LOAD;
                end
            end
            SERVE: begin
                if (bus.Start) begin
                    state_nxt_s = LOAD;
                end else begin
                    state_nxt_s = SERVE;
                end
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Load entry counter: doubles as the row-major write address.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            cnt_r <= '0;
        end else if (bus.Start) begin
            cnt_r <= '0;
        end else if (accept_s) begin
            cnt_r <= last_s ? '0 : cnt_r + {{(AW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    // Sticky flag for load data offered while not loading.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            load_err_r <= 1'b0;
        end else if (bus.Start) begin
            load_err_r <= 1'b0;
        end else if (bus.LdValid && (state_r != LOAD)) begin
            load_err_r <= 1'b1;
        end else begin
            load_err_r <= load_err_r;
        end
    end

    // Previous lookup indices, tracked every cycle so the first SERVE cycle
    // compares against what was applied during the final load cycle.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            prev_wj_r <= 6'd0;
        end else begin
            prev_wj_r <= wj_s;
        end
    end

    // Lookup counter: cleared when the load completes, counts index changes.
    always_ff @(posedge CLK) begin
        if (!RST) begin
            lookups_r <= 16'd0;
        end else if (accept_s && last_s) begin
            lookups_r <= 16'd0;
        end else if ((state_r == SERVE) && (wj_s != prev_wj_r)) begin
            lookups_r <= sat_inc16(lookups_r);
        end else begin
            lookups_r <= lookups_r;
        end
    end

    // Read address decode; out-of-range indices park the address at 0 and
    // force Cost to 0 below.
    always_comb begin
        in_range_s = 1'b0;
        raddr_s    = '0;
        if ((32'(bus.W) < N) && (32'(bus.J) < N)) begin
            in_range_s = 1'b1;
            raddr_s    = AW'(32'(bus.W) * N + 32'(bus.J));
        end else begin
            in_range_s = 1'b0;
            raddr_s    = '0;
        end
    end

    cost_mem #(
        .DEPTH  (DEPTH),
        .COST_W (COST_W),
        .AW     (AW)
    ) u_mem (
        .CLK    (CLK),
        .we     (accept_s),
        .waddr  (cnt_r),
        .wdata  (bus.LdData),
        .raddr  (raddr_s),
        .rdata  (rdata_s)
    );

    // Cost is a zero-latency read, gated to SERVE and valid indices.
    always_comb begin
        bus.Cost = '0;
        if ((state_r == SERVE) && in_range_s) begin
            bus.Cost = rdata_s;
        end else begin
            bus.Cost = '0;
        end
    end

    assign bus.LdReady = (state_r == LOAD);
    assign bus.Ready   = (state_r == SERVE);
    assign bus.LoadErr = load_err_r;
    assign bus.Lookups = lookups_r;
endmodule

// File: doc/cost_table.md
COST_TABLE -- requirements
Module: cost_table

Interface
REQ-001 Parameter N, default 8, matrix dimension; workers and jobs are indexed 0..N-1.
REQ-002 Parameter COST_W, default 7, width of one cost entry.
REQ-003 CLK  input  1  single clock; all state changes on the rising edge.
REQ-004 RST  input  1  reset, synchronous and active-low.
REQ-005 Start  input  1  one-cycle pulse that begins a load of the full matrix.
REQ-006 LdValid  input  1  a load entry is presented on LdData.
REQ-007 LdData  input  COST_W  load entry, row-major order: worker 0 jobs 0..N-1 first, then worker 1, and so on.
REQ-008 LdReady  output  1  block accepts LdData this cycle.
REQ-009 W  input  3  worker index for lookup.
REQ-010 J  input  3  job index for lookup.
REQ-011 Cost  output  COST_W  cost of worker W doing job J.
REQ-012 Ready  output  1  matrix fully loaded; Cost is valid.
REQ-013 LoadErr  output  1  sticky flag: LdValid was seen outside LOAD.
REQ-014 Lookups  output  16  count of served lookups since the last completed load.

Function
REQ-015 The FSM SHALL have three states: IDLE, LOAD and SERVE.
REQ-016 In IDLE, a Start pulse SHALL move the FSM to LOAD and clear the entry counter to 0.
REQ-017 LdReady SHALL be 1 only in LOAD.
REQ-018 An entry SHALL be accepted on a rising edge where LdValid=1 and LdReady=1. It is written to table[cnt/N][cnt%N], and cnt increments.
REQ-019 If LdValid=0 in LOAD, the block SHALL hold: no write and no counter change, for any number of cycles.
REQ-020 Acceptance of entry N*N-1 SHALL move the FSM to SERVE on the same edge and clear Lookups to 0; Ready rises the next cycle.
REQ-021 Ready SHALL be 1 exactly when the state is SERVE.
REQ-022 In SERVE, Cost SHALL be combinational from the registered table: Cost = table[W][J] in the same cycle W and J are applied, with zero-cycle latency.
REQ-023 Outside SERVE, Cost SHALL be 0.
REQ-024 In SERVE, Lookups SHALL increment every cycle in which (W,J) differs from its value on the previous cycle. It saturates at 16'hFFFF.
REQ-025 Start in SERVE SHALL begin a reload: go to LOAD, clear cnt, drop Ready. Old table contents persist until overwritten.
REQ-026 Start in LOAD SHALL restart the load from cnt=0; no entry is accepted on that edge.
REQ-027 LdValid=1 in IDLE or SERVE SHALL set LoadErr and SHALL NOT write the table. LoadErr clears only on reset or on Start.
REQ-028 When W or J is at least N, in SERVE, Cost SHALL be 0.

Reset
REQ-029 When RST=0 at a rising edge, the block SHALL reset:
- state to IDLE, cnt to 0, Lookups to 0, LoadErr to 0;
- Ready, LdReady and Cost to 0;
- table contents are not reset.
REQ-030 Reset asserted mid-LOAD SHALL abandon the load; a fresh Start is required.

Structure
REQ-031 A shared package SHALL hold:
- the state encoding (IDLE=0, LOAD=1, SERVE=2);
- N and COST_W defaults;
- the Lookups saturation constant.
REQ-032 The N*N x COST_W storage SHALL be a separate sub-module, cost_mem, with one synchronous write port and one combinational read port.

Verification
REQ-033 Reset, then hold RST=1 for 3 cycles with no Start -> Ready=0, LdReady=0, Cost=0, Lookups=0.
REQ-034 Start, then 64 back-to-back entries with value = (w*8+j)%128 -> Ready=1 one cycle after the last accept; W=3, J=5 gives Cost=29 in the same cycle.
REQ-035 Load with LdValid dropped for 5 cycles after entry 10 -> cnt holds at 11; final table is identical to the back-to-back case.
REQ-036 Load all entries = 1 while sweeping W and J 0..7 in SERVE -> every Cost=1, and Lookups=63 after 64 distinct consecutive pairs.
REQ-037 Pulse LdValid=1 in SERVE -> LoadErr=1 and the table is unchanged; a following Start clears LoadErr and drops Ready.
REQ-038 Assert RST=0 after 20 entries, then Start plus a 64-entry reload -> Ready only after all 64 new entries, and Cost reflects the new values.
